pipeline_ctrl: RTL and testbench



---
 rtl/pipeline_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: ID decode, stage control registers, hazard stall/flush and EX forwarding selects
module pipeline_ctrl #(
    parameter int AW     = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [6:0]    op_i,
    input  logic [AW-1:0] rs1_i,
    input  logic [AW-1:0] rs2_i,
    input  logic [AW-1:0] rd_i,
    input  logic          branch_taken_i,
    output logic          stall_o,
    output logic          flush_o,
    output logic          id_branch_o,
    output logic [1:0]    ex_alu_op_o,
    output logic          ex_alu_src_o,
    output logic [AW-1:0] ex_rs1_o,
    output logic [AW-1:0] ex_rs2_o,
    output logic [1:0]    fwd_a_o,
    output logic [1:0]    fwd_b_o,
    output logic          mem_mem_read_o,
    output logic          mem_mem_write_o,
    output logic [AW-1:0] mem_rd_o,
    output logic          wb_reg_write_o,
    output logic          wb_mem_to_reg_o,
    output logic [AW-1:0] wb_rd_o
);
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic          d_reg_write, d_mem_to_reg, d_mem_read, d_mem_write, d_branch, d_alu_src;
    logic [1:0]    d_alu_op;
    logic          use_rs1, use_rs2;

    logic          ex_reg_write_q, ex_mem_to_reg_q, ex_mem_read_q, ex_mem_write_q, ex_alu_src_q;
    logic [1:0]    ex_alu_op_q;
    logic [AW-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
    logic          ex_reg_write_d, ex_mem_to_reg_d, ex_mem_read_d, ex_mem_write_d, ex_alu_src_d;
    logic [1:0]    ex_alu_op_d;
    logic [AW-1:0] ex_rd_d, ex_rs1_d, ex_rs2_d;

    logic          mem_reg_write_q, mem_mem_to_reg_q, mem_mem_read_q, mem_mem_write_q;
    logic [AW-1:0] mem_rd_q;
    logic          wb_reg_write_q, wb_mem_to_reg_q;
    logic [AW-1:0] wb_rd_q;

    logic          ex_hit, mem_hit, load_use, branch_haz, nofwd_haz;
    logic          mem_fwd_ok, wb_fwd_ok;

    // Decode the ID opcode into control bits and which source fields it actually reads
    always_comb begin
        {d_reg_write, d_mem_to_reg, d_mem_read, d_mem_write, d_branch, d_alu_src, d_alu_op} = 8'b0;
        {use_rs1, use_rs2} = 2'b00;
        case (op_i)
            OP_R:    begin {d_reg_write, d_mem_to_reg, d_mem_read, d_mem_write, d_branch, d_alu_src, d_alu_op} = 8'b1000_0010; {use_rs1, use_rs2} = 2'b11; end
            OP_I:    begin {d_reg_write, d_mem_to_reg, d_mem_read, d_mem_write, d_branch, d_alu_src, d_alu_op} = 8'b1000_0111; {use_rs1, use_rs2} = 2'b10; end
            OP_LW:   begin {d_reg_write, d_mem_to_reg, d_mem_read, d_mem_write, d_branch, d_alu_src, d_alu_op} = 8'b1110_0100; {use_rs1, use_rs2} = 2'b10; end
            OP_SW:   begin {d_reg_write, d_mem_to_reg, d_mem_read, d_mem_write, d_branch, d_alu_src, d_alu_op} = 8'b0001_0100; {use_rs1, use_rs2} = 2'b11; end
            OP_BEQ:  begin {d_reg_write, d_mem_to_reg, d_mem_read, d_mem_write, d_branch, d_alu_src, d_alu_op} = 8'b0000_1001; {use_rs1, use_rs2} = 2'b11; end
            default: ;
        endcase
    end

    // A stage "hits" when it writes a nonzero rd that the ID instruction reads
    assign ex_hit  = ex_reg_write_q && ex_rd_q != '0 &&
                     ((use_rs1 && ex_rd_q == rs1_i) || (use_rs2 && ex_rd_q == rs2_i));
    assign mem_hit = mem_reg_write_q && mem_rd_q != '0 &&
                     ((use_rs1 && mem_rd_q == rs1_i) || (use_rs2 && mem_rd_q == rs2_i));

    // The ID-stage comparator needs final values, so beq waits out EX writers and MEM loads
    assign load_use   = ex_mem_read_q && ex_hit;
    assign branch_haz = d_branch && (ex_hit || (mem_mem_read_q && mem_hit));
    assign nofwd_haz  = !FWD_EN && (ex_hit || mem_hit);

    assign stall_o     = !rst_i && (load_use || branch_haz || nofwd_haz);
    assign id_branch_o = !rst_i && d_branch;
    assign flush_o     = id_branch_o && branch_taken_i && !stall_o;

    // EX/MEM result is newer than MEM/WB, so it wins when both match
    assign mem_fwd_ok = FWD_EN && mem_reg_write_q && mem_rd_q != '0;
    assign wb_fwd_ok  = FWD_EN && wb_reg_write_q && wb_rd_q != '0;
    assign fwd_a_o    = (mem_fwd_ok && mem_rd_q == ex_rs1_q) ? 2'b10 :
                        (wb_fwd_ok && wb_rd_q == ex_rs1_q) ? 2'b01 : 2'b00;
    assign fwd_b_o    = (mem_fwd_ok && mem_rd_q == ex_rs2_q) ? 2'b10 :
                        (wb_fwd_ok && wb_rd_q == ex_rs2_q) ? 2'b01 : 2'b00;

    // ID/EX next state: a stall injects an all-zero bubble
    always_comb begin
        ex_reg_write_d  = stall_o ? 1'b0 : d_reg_write;
        ex_mem_to_reg_d = stall_o ? 1'b0 : d_mem_to_reg;
        ex_mem_read_d   = stall_o ? 1'b0 : d_mem_read;
        ex_mem_write_d  = stall_o ? 1'b0 : d_mem_write;
        ex_alu_src_d    = stall_o ? 1'b0 : d_alu_src;
        ex_alu_op_d     = stall_o ? 2'b00 : d_alu_op;
        ex_rd_d         = stall_o ? '0 : rd_i;
        ex_rs1_d        = stall_o ? '0 : rs1_i;
        ex_rs2_d        = stall_o ? '0 : rs2_i;
    end

    // ID/EX stage register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_reg_write_q  <= 1'b0;
            ex_mem_to_reg_q <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_alu_src_q    <= 1'b0;
            ex_alu_op_q     <= 2'b00;
            ex_rd_q         <= '0;
            ex_rs1_q        <= '0;
            ex_rs2_q        <= '0;
        end else begin
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_to_reg_q <= ex_mem_to_reg_d;
            ex_mem_read_q   <= ex_mem_read_d;
            ex_mem_write_q  <= ex_mem_write_d;
            ex_alu_src_q    <= ex_alu_src_d;
            ex_alu_op_q     <= ex_alu_op_d;
            ex_rd_q         <= ex_rd_d;
            ex_rs1_q        <= ex_rs1_d;
            ex_rs2_q        <= ex_rs2_d;
        end
    end

    // EX/MEM and MEM/WB always advance; reset discards everything in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_reg_write_q  <= 1'b0;
            mem_mem_to_reg_q <= 1'b0;
            mem_mem_read_q   <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            mem_rd_q         <= '0;
            wb_reg_write_q   <= 1'b0;
            wb_mem_to_reg_q  <= 1'b0;
            wb_rd_q          <= '0;
        end else begin
            mem_reg_write_q  <= ex_reg_write_q;
            mem_mem_to_reg_q <= ex_mem_to_reg_q;
            mem_mem_read_q   <= ex_mem_read_q;
            mem_mem_write_q  <= ex_mem_write_q;
            mem_rd_q         <= ex_rd_q;
            wb_reg_write_q   <= mem_reg_write_q;
            wb_mem_to_reg_q  <= mem_mem_to_reg_q;
            wb_rd_q          <= mem_rd_q;
        end
    end

    assign ex_alu_op_o     = ex_alu_op_q;
    assign ex_alu_src_o    = ex_alu_src_q;
    assign ex_rs1_o        = ex_rs1_q;
    assign ex_rs2_o        = ex_rs2_q;
    assign mem_mem_read_o  = mem_mem_read_q;
    assign mem_mem_write_o = mem_mem_write_q;
    assign mem_rd_o        = mem_rd_q;
    assign wb_reg_write_o  = wb_reg_write_q;
    assign wb_mem_to_reg_o = wb_mem_to_reg_q;
    assign wb_rd_o         = wb_rd_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scenarios plus randomized run against an in-order pipeline model, both FWD_EN builds
module tb_pipeline_ctrl;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = '0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       taken = 1'b0;

    logic [1:0] stall, flush, idbr, alusrc, mr, mw, rw, m2r;
    logic [1:0] aluop [2];
    logic [1:0] fa [2];
    logic [1:0] fb [2];
    logic [4:0] exrs1 [2];
    logic [4:0] exrs2 [2];
    logic [4:0] memrd [2];
    logic [4:0] wbrd [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // index 0: FWD_EN=0 build, index 1: FWD_EN=1 build; both see the same ID stream
    for (genvar g = 0; g < 2; g++) begin : g_dut
        pipeline_ctrl #(.AW(5), .FWD_EN(g == 1)) u_dut (
            .clk_i(clk), .rst_i(rst), .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
            .branch_taken_i(taken), .stall_o(stall[g]), .flush_o(flush[g]), .id_branch_o(idbr[g]),
            .ex_alu_op_o(aluop[g]), .ex_alu_src_o(alusrc[g]), .ex_rs1_o(exrs1[g]), .ex_rs2_o(exrs2[g]),
            .fwd_a_o(fa[g]), .fwd_b_o(fb[g]), .mem_mem_read_o(mr[g]), .mem_mem_write_o(mw[g]),
            .mem_rd_o(memrd[g]), .wb_reg_write_o(rw[g]), .wb_mem_to_reg_o(m2r[g]), .wb_rd_o(wbrd[g])
        );
    end

    // Model: each stage slot holds the whole instruction that occupies it (zero = bubble)
    typedef struct packed {
        logic [6:0] op;
        logic [4:0] rs1, rs2, rd;
    } instr_t;

    instr_t mp [2][3];
    logic   mst [2];

    function automatic logic writes(input logic [6:0] o);
        return o == OP_R || o == OP_I || o == OP_LW;
    endfunction

    function automatic logic reads1(input logic [6:0] o);
        return o == OP_R || o == OP_I || o == OP_LW || o == OP_SW || o == OP_BEQ;
    endfunction

    function automatic logic reads2(input logic [6:0] o);
        return o == OP_R || o == OP_SW || o == OP_BEQ;
    endfunction

    function automatic logic dep(input instr_t w, input instr_t r);
        return writes(w.op) && w.rd != 0 && ((reads1(r.op) && w.rd == r.rs1) || (reads2(r.op) && w.rd == r.rs2));
    endfunction

    function automatic instr_t cur();
        return {op, rs1, rs2, rd};
    endfunction

    function automatic logic model_stall(input int b);
        instr_t c = cur();
        instr_t e = mp[b][0];
        instr_t m = mp[b][1];
        if (rst) return 1'b0;
        return (e.op == OP_LW && dep(e, c)) ||
               (c.op == OP_BEQ && (dep(e, c) || (m.op == OP_LW && dep(m, c)))) ||
               (b == 0 && (dep(e, c) || dep(m, c)));
    endfunction

    function automatic logic [1:0] model_fwd(input int b, input logic [4:0] r);
        if (b == 1 && writes(mp[b][1].op) && mp[b][1].rd != 0 && mp[b][1].rd == r) return 2'b10;
        if (b == 1 && writes(mp[b][2].op) && mp[b][2].rd != 0 && mp[b][2].rd == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [1:0] alu_class(input logic [6:0] o);
        return o == OP_R ? 2'b10 : o == OP_I ? 2'b11 : o == OP_BEQ ? 2'b01 : 2'b00;
    endfunction

    function automatic logic [33:0] exp_vec(input int b);
        instr_t e = mp[b][0];
        instr_t m = mp[b][1];
        instr_t w = mp[b][2];
        logic   s = model_stall(b);
        logic   ib = !rst && op == OP_BEQ;
        return {s, ib && taken && !s, ib, alu_class(e.op), (e.op == OP_I || e.op == OP_LW || e.op == OP_SW),
                e.rs1, e.rs2, model_fwd(b, e.rs1), model_fwd(b, e.rs2),
                m.op == OP_LW, m.op == OP_SW, m.rd, writes(w.op), w.op == OP_LW, w.rd};
    endfunction

    function automatic logic [33:0] got_vec(input int b);
        return {stall[b], flush[b], idbr[b], aluop[b], alusrc[b], exrs1[b], exrs2[b], fa[b], fb[b],
                mr[b], mw[b], memrd[b], rw[b], m2r[b], wbrd[b]};
    endfunction

    task automatic drive(input logic [6:0] o, input logic [4:0] a, input logic [4:0] c, input logic [4:0] d, input logic t);
        op = o; rs1 = a; rs2 = c; rd = d; taken = t;
        #1;
    endtask

    task automatic tick();
        for (int b = 0; b < 2; b++) mst[b] = model_stall(b);
        @(posedge clk);
        for (int b = 0; b < 2; b++) begin
            if (rst) begin
                for (int j = 0; j < 3; j++) mp[b][j] = '0;
            end else begin
                mp[b][2] = mp[b][1];
                mp[b][1] = mp[b][0];
                mp[b][0] = mst[b] ? '0 : cur();
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(OP_R, 5'd1, 5'd2, 5'd3, 1'b1);
        for (int c = 0; c < 2; c++) begin
            tick();
            for (int b = 0; b < 2; b++) begin
                checks++; if (got_vec(b) !== 34'd0) begin errors++; $display("FAIL reset_outputs b%0d cyc%0d got=%h exp=0", b, c, got_vec(b)); end
            end
        end
        rst = 1'b0;
        drive(OP_R, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        checks++; if (aluop[1] !== 2'b10) begin errors++; $display("FAIL reset_first_alu_op got=%b exp=10", aluop[1]); end
        checks++; if (exrs1[1] !== 5'd1) begin errors++; $display("FAIL reset_first_rs1 got=%0d exp=1", exrs1[1]); end
    endtask

    task automatic test_rtype();
        do_reset();
        drive(OP_R, 5'd1, 5'd2, 5'd3, 1'b0);
        checks++; if (stall[1] !== 1'b0) begin errors++; $display("FAIL rtype_stall got=%b exp=0", stall[1]); end
        tick();
        drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        checks++; if ({aluop[1], alusrc[1]} !== 3'b100) begin errors++; $display("FAIL rtype_ex got=%b exp=100", {aluop[1], alusrc[1]}); end
        tick();
        checks++; if ({memrd[1], mr[1]} !== {5'd3, 1'b0}) begin errors++; $display("FAIL rtype_mem got=%h exp=%h", {memrd[1], mr[1]}, {5'd3, 1'b0}); end
        tick();
        checks++; if ({rw[1], wbrd[1], m2r[1]} !== {1'b1, 5'd3, 1'b0}) begin errors++; $display("FAIL rtype_wb got=%h exp=%h", {rw[1], wbrd[1], m2r[1]}, {1'b1, 5'd3, 1'b0}); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(OP_LW, 5'd1, 5'd0, 5'd5, 1'b0);
        tick();
        drive(OP_R, 5'd5, 5'd1, 5'd6, 1'b0);
        checks++; if (stall[1] !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", stall[1]); end
        tick();
        checks++; if ({aluop[1], alusrc[1], exrs1[1], exrs2[1]} !== 13'd0) begin errors++; $display("FAIL lu_bubble got=%h exp=0", {aluop[1], alusrc[1], exrs1[1], exrs2[1]}); end
        checks++; if (stall[1] !== 1'b0) begin errors++; $display("FAIL lu_stall_len got=%b exp=0", stall[1]); end
        tick();
        drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        checks++; if ({fa[1], fb[1]} !== 4'b0100) begin errors++; $display("FAIL lu_fwd got=%b exp=0100", {fa[1], fb[1]}); end
        checks++; if ({m2r[1], rw[1], wbrd[1]} !== {1'b1, 1'b1, 5'd5}) begin errors++; $display("FAIL lu_wb got=%h exp=%h", {m2r[1], rw[1], wbrd[1]}, {1'b1, 1'b1, 5'd5}); end
    endtask

    task automatic test_fwd_priority();
        do_reset();
        drive(OP_R, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        drive(OP_R, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        drive(OP_R, 5'd3, 5'd3, 5'd4, 1'b0);
        checks++; if (stall[1] !== 1'b0) begin errors++; $display("FAIL prio_stall got=%b exp=0", stall[1]); end
        tick();
        drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        checks++; if ({fa[1], fb[1]} !== 4'b1010) begin errors++; $display("FAIL prio_fwd got=%b exp=1010", {fa[1], fb[1]}); end
        do_reset();
        drive(OP_R, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        drive(OP_R, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        drive(OP_R, 5'd0, 5'd0, 5'd4, 1'b0);
        checks++; if (stall !== 2'b00) begin errors++; $display("FAIL x0_stall got=%b exp=00", stall); end
        tick();
        drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        checks++; if ({fa[1], fb[1]} !== 4'b0000) begin errors++; $display("FAIL x0_fwd got=%b exp=0000", {fa[1], fb[1]}); end
    endtask

    task automatic test_branch();
        do_reset();
        drive(OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b1);
        checks++; if ({idbr[1], stall[1], flush[1]} !== 3'b101) begin errors++; $display("FAIL br_flush got=%b exp=101", {idbr[1], stall[1], flush[1]}); end
        tick();
        drive(OP_LW, 5'd1, 5'd0, 5'd7, 1'b0);
        tick();
        drive(OP_BEQ, 5'd7, 5'd1, 5'd0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            checks++; if ({stall[1], flush[1]} !== {c < 2, c == 2}) begin errors++; $display("FAIL br_lw cyc%0d got=%b exp=%b", c, {stall[1], flush[1]}, {c < 2, c == 2}); end
            tick();
        end
    endtask

    task automatic test_nofwd();
        do_reset();
        drive(OP_R, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        drive(OP_R, 5'd3, 5'd1, 5'd4, 1'b0);
        for (int c = 0; c < 3; c++) begin
            checks++; if ({stall[0], fa[0], fb[0]} !== {c < 2, 4'b0000}) begin errors++; $display("FAIL nofwd_alu cyc%0d got=%b exp=%b", c, {stall[0], fa[0], fb[0]}, {c < 2, 4'b0000}); end
            tick();
        end
        drive(OP_LW, 5'd1, 5'd0, 5'd5, 1'b0);
        tick();
        drive(OP_R, 5'd5, 5'd2, 5'd6, 1'b0);
        for (int c = 0; c < 3; c++) begin
            checks++; if ({stall[0], fa[0], fb[0]} !== {c < 2, 4'b0000}) begin errors++; $display("FAIL nofwd_lw cyc%0d got=%b exp=%b", c, {stall[0], fa[0], fb[0]}, {c < 2, 4'b0000}); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [33:0] exp;
        int sel;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (!(model_stall(0) || model_stall(1))) begin
                sel = $urandom_range(0, 5);
                op = sel == 0 ? OP_R : sel == 1 ? OP_I : sel == 2 ? OP_LW : sel == 3 ? OP_SW : sel == 4 ? OP_BEQ : 7'($urandom);
                rs1 = 5'($urandom_range(0, 3));
                rs2 = 5'($urandom_range(0, 3));
                rd = 5'($urandom_range(0, 3));
            end
            rst = $urandom_range(0, 39) == 0;
            drive(op, rs1, rs2, rd, 1'($urandom));
            for (int b = 0; b < 2; b++) begin
                exp = exp_vec(b);
                checks++; if (got_vec(b) !== exp) begin errors++; $display("FAIL rand_b%0d cyc%0d got=%h exp=%h", b, n, got_vec(b), exp); end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int b = 0; b < 2; b++) for (int j = 0; j < 3; j++) mp[b][j] = '0;
        test_reset();
        test_rtype();
        test_load_use();
        test_fwd_priority();
        test_branch();
        test_nofwd();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
